// File: rtl/pll_scan_cfg.sv
// PLL reconfiguration engine: encodes M, N and C0..C(NUM_CLK-1) divides into scan words,
// shifts them MSB first into the PLL scan port, pulses configupdate and waits for scan-done.
module pll_scan_cfg #(
   parameter int NUM_CLK = 5,
   parameter int DIV_W   = 8,
   parameter int TIMEOUT = 1024,
   parameter int RST_CYC = 4
) (
   input  logic                     clock,
   input  logic                     rst_n,
   input  logic                     update_req,
   input  logic [DIV_W-1:0]         Mult,
   input  logic [DIV_W-1:0]         div,
   input  logic [NUM_CLK*DIV_W-1:0] clk_div,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic                     to_pll_scan_clk,
   output logic                     to_pll_scan_ena,
   output logic                     to_pll_scan_data,
   output logic                     to_pll_update,
   output logic                     to_pll_rst,
   input  logic                     from_pll_scan_done
);

   localparam int WW = 2*DIV_W + 2;
   localparam int L  = (NUM_CLK + 2) * WW;
   localparam int BW = $clog2(L);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int RW = $clog2(RST_CYC + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(L - 1);
   localparam logic [TW-1:0] LAST_T   = TW'(TIMEOUT - 1);
   localparam logic [RW-1:0] RST_INIT = RW'(RST_CYC - 1);

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, UPDATE, WAIT_DONE, FIN, ERR} state_t;

   state_t                     state, state_nxt;
   logic                       phase, phase_nxt;
   logic [BW-1:0]              bit_cnt, bit_cnt_nxt;
   logic [TW-1:0]              tcnt, tcnt_nxt;
   logic [RW-1:0]              rst_cnt;
   logic [L-1:0]               sreg, sreg_nxt, load_word;
   logic                       capture;
   logic [DIV_W-1:0]           mult_q, div_q;
   logic [NUM_CLK*DIV_W-1:0]   cdiv_q;
   logic                       sync_p0, sync_p1;

   // word = {bypass, high, odd, low}; d<=1 is exactly the case floor(d/2)==0
   function automatic logic [WW-1:0] enc(input logic [DIV_W-1:0] d);
      logic [DIV_W-1:0] lo;
      lo = {1'b0, d[DIV_W-1:1]};
      if (lo == '0) return {1'b1, {(WW-1){1'b0}}};
      return {1'b0, lo + DIV_W'(d[0]), d[0], lo};
   endfunction

   always_comb begin
      load_word = '0;
      load_word[L-1 -: WW]    = enc(mult_q);
      load_word[L-1-WW -: WW] = enc(div_q);
      for (int k = 0; k < NUM_CLK; k++)
         load_word[L-1-(k+2)*WW -: WW] = enc(cdiv_q[k*DIV_W +: DIV_W]);
   end

   always_ff @(posedge clock) begin
      if (capture) begin
         mult_q <= Mult;
         div_q  <= div;
         cdiv_q <= clk_div;
      end
   end

   // scan-done crosses from the PLL domain
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= from_pll_scan_done;
         sync_p1 <= sync_p0;
      end
   end

   always_comb begin
      state_nxt   = state;
      phase_nxt   = phase;
      bit_cnt_nxt = bit_cnt;
      tcnt_nxt    = tcnt;
      sreg_nxt    = sreg;
      capture     = 1'b0;
      case (state)
         IDLE: begin
            if (update_req) begin
               capture   = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            sreg_nxt    = load_word;
            bit_cnt_nxt = '0;
            phase_nxt   = 1'b0;
            state_nxt   = SHIFT;
         end
         SHIFT: begin
            if (!phase) begin
               phase_nxt = 1'b1;
            end else begin
               phase_nxt = 1'b0;
               sreg_nxt  = {sreg[L-2:0], 1'b0};
               if (bit_cnt == LAST_BIT) state_nxt = UPDATE;
               else bit_cnt_nxt = bit_cnt + BW'(1);
            end
         end
         UPDATE: begin
            tcnt_nxt  = '0;
            state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (sync_p1) state_nxt = FIN;
            else if (tcnt == LAST_T) state_nxt = ERR;
            else tcnt_nxt = tcnt + TW'(1);
         end
         default: state_nxt = IDLE;
      endcase
   end

   // outputs are registered from the next-state decode so they line up with the state
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         phase           <= 1'b0;
         bit_cnt         <= '0;
         tcnt            <= '0;
         sreg            <= '0;
         rst_cnt         <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
         to_pll_scan_clk <= 1'b0;
         to_pll_scan_ena <= 1'b0;
         to_pll_update   <= 1'b0;
         to_pll_rst      <= 1'b1;
      end else begin
         state           <= state_nxt;
         phase           <= phase_nxt;
         bit_cnt         <= bit_cnt_nxt;
         tcnt            <= tcnt_nxt;
         sreg            <= sreg_nxt;
         busy            <= (state_nxt != IDLE);
         done            <= (state_nxt == FIN);
         error           <= (state_nxt == ERR);
         to_pll_scan_clk <= (state_nxt == SHIFT) && phase_nxt;
         to_pll_scan_ena <= (state_nxt == SHIFT);
         to_pll_update   <= (state_nxt == UPDATE);
         if (state_nxt == ERR) begin
            to_pll_rst <= 1'b1;
            rst_cnt    <= RST_INIT;
         end else if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - RW'(1);
         end else begin
            to_pll_rst <= 1'b0;
         end
      end
   end

   assign to_pll_scan_data = sreg[L-1];

endmodule
